// File: rtl/ryu_anim_seq.sv
// Punch animation sequencer and horizontal mover for a fighter sprite.
// All outputs are registered and change only on the cycle after the vertical-blank tick.
module ryu_anim_seq #(
   parameter int FRAME_HOLD = 4,
   parameter int X_INIT     = 100,
   parameter int X_MAX      = 548,
   parameter int STEP       = 2,
   parameter int Y_FIXED    = 300
) (
   input  logic        vga_clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        punch_req,
   input  logic        move_left,
   input  logic        move_right,
   output logic [9:0]  sprite_x,
   output logic [9:0]  sprite_y,
   output logic [1:0]  frame_sel,
   output logic [15:0] rom_base,
   output logic        busy,
   output logic        hit_active
);

   // Encoding doubles as the animation frame index, so frame_sel is the FSM state.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WINDUP  = 2'd1,
      STRIKE  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   localparam logic [3:0]  HOLD_RELOAD = 4'(FRAME_HOLD - 1);
   localparam logic [10:0] STEP_W      = 11'(STEP);
   localparam logic [10:0] X_MAX_W     = 11'(X_MAX);

   state_t      state_q, state_d;
   logic [3:0]  hold_q, hold_d;
   logic        pending_q, pending_d;
   logic        punch_prev_q;
   logic [9:0]  x_q, x_d;
   logic [15:0] rom_q, rom_d;
   logic        busy_q, busy_d;
   logic        hit_q, hit_d;
   logic        frame_tick;
   logic        punch_edge;

   assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd480);
   assign punch_edge = punch_req & ~punch_prev_q;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      pending_d = pending_q;
      x_d       = x_q;
      // Requests seen outside IDLE are dropped rather than queued.
      if (punch_edge) pending_d = (state_q == IDLE);
      if (frame_tick) begin
         if (state_q == IDLE) begin
            if (pending_q) begin
               state_d   = WINDUP;
               hold_d    = HOLD_RELOAD;
               pending_d = 1'b0;
            end else if (move_left && !move_right) begin
               x_d = ({1'b0, x_q} < STEP_W) ? 10'd0 : 10'({1'b0, x_q} - STEP_W);
            end else if (move_right && !move_left) begin
               x_d = ({1'b0, x_q} + STEP_W > X_MAX_W) ? 10'(X_MAX) : 10'({1'b0, x_q} + STEP_W);
            end
         end else if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
         end else begin
            case (state_q)
               WINDUP:  state_d = STRIKE;
               STRIKE:  state_d = RECOVER;
               default: state_d = IDLE;
            endcase
            if (state_q != RECOVER) hold_d = HOLD_RELOAD;
         end
      end
      rom_d  = {14'd0, state_d} * 16'd8280;
      busy_d = (state_d != IDLE);
      hit_d  = (state_d == STRIKE);
   end

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         hold_q       <= 4'd0;
         pending_q    <= 1'b0;
         punch_prev_q <= 1'b0;
         x_q          <= 10'(X_INIT);
         rom_q        <= 16'd0;
         busy_q       <= 1'b0;
         hit_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         pending_q    <= pending_d;
         punch_prev_q <= punch_req;
         x_q          <= x_d;
         rom_q        <= rom_d;
         busy_q       <= busy_d;
         hit_q        <= hit_d;
      end
   end

   assign frame_sel  = state_q;
   assign rom_base   = rom_q;
   assign busy       = busy_q;
   assign hit_active = hit_q;
   assign sprite_x   = x_q;
   assign sprite_y   = 10'(Y_FIXED);

endmodule

// File: tb/tb_ryu_anim_seq.sv
// Bench for ryu_anim_seq: a shrunken raster drives frame ticks; expected per-tick snapshots
// go into a queue and a negedge monitor pops them, also holding outputs steady on visible pixels.
`timescale 1ns/1ps
module tb_ryu_anim_seq;

   logic        clk = 1'b0;
   logic        Reset = 1'b0;
   logic [9:0]  DrawX = 10'd0;
   logic [9:0]  DrawY = 10'd500;
   logic        punch_req = 1'b0;
   logic        move_left = 1'b0;
   logic        move_right = 1'b0;
   logic [9:0]  sprite_x, sprite_y;
   logic [1:0]  frame_sel;
   logic [15:0] rom_base;
   logic        busy, hit_active;

   logic [39:0] exp_q[$];
   logic [39:0] cur_exp;
   bit          have_exp = 1'b0;
   bit          pop_pend = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          vis_rows[4] = '{0, 1, 240, 479};

   ryu_anim_seq dut (
      .vga_clk    (clk),
      .Reset      (Reset),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .punch_req  (punch_req),
      .move_left  (move_left),
      .move_right (move_right),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .frame_sel  (frame_sel),
      .rom_base   (rom_base),
      .busy       (busy),
      .hit_active (hit_active)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: run exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   // Expected snapshot: {frame_sel, busy, hit_active, rom_base, sprite_x, sprite_y}
   function automatic logic [39:0] mk(input logic [1:0] fs, input int x);
      logic [15:0] rb;
      case (fs)
         2'd0: rb = 16'd0;
         2'd1: rb = 16'd8280;
         2'd2: rb = 16'd16560;
         default: rb = 16'd24840;
      endcase
      return {fs, fs != 2'd0, fs == 2'd2, rb, 10'(x), 10'd300};
   endfunction

   task automatic check(input string nm, input logic [39:0] e);
      logic [39:0] a;
      a = {frame_sel, busy, hit_active, rom_base, sprite_x, sprite_y};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s @%0t: got fs=%0d busy=%0b hit=%0b rom=%0d x=%0d y=%0d, want fs=%0d busy=%0b hit=%0b rom=%0d x=%0d y=%0d",
                  nm, $time, a[39:38], a[37], a[36], a[35:20], a[19:10], a[9:0],
                  e[39:38], e[37], e[36], e[35:20], e[19:10], e[9:0]);
      end
   endtask

   // Monitor: pop after each tick or reset cycle, otherwise hold on visible pixels
   always @(negedge clk) begin
      if (pop_pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL underflow @%0t: DUT update with empty expected queue, got fs=%0d x=%0d",
                     $time, frame_sel, sprite_x);
         end else begin
            cur_exp  = exp_q.pop_front();
            have_exp = 1'b1;
            check("tick", cur_exp);
         end
      end else if (have_exp && DrawY < 10'd480 && !Reset) begin
         check("visible", cur_exp);
      end
      pop_pend = Reset || (DrawX == 10'd0 && DrawY == 10'd480);
   end

   // Driver tasks
   task automatic cyc(input int x, input int y);
      @(posedge clk);
      #1;
      DrawX = 10'(x);
      DrawY = 10'(y);
   endtask

   task automatic do_reset();
      exp_q.push_back(mk(2'd0, 100));
      cyc(0, 500);
      Reset = 1'b1;
      cyc(1, 500);
      Reset = 1'b0;
   endtask

   // pmode: 0 none, 1 pulse on a visible row, 2 rising edge on the tick cycle
   task automatic frame(input int pmode, input bit rst_tick, input logic [39:0] e);
      for (int r = 0; r < 4; r++) begin
         for (int x = 0; x < 8; x++) begin
            cyc(x, vis_rows[r]);
            if (pmode == 1 && r == 1) punch_req = (x >= 2 && x < 5);
         end
      end
      exp_q.push_back(e);
      cyc(0, 480);
      Reset = rst_tick;
      if (pmode == 2) punch_req = 1'b1;
      cyc(1, 480);
      Reset = 1'b0;
      for (int x = 2; x < 8; x++) cyc(x, 480);
      cyc(0, 500);
      punch_req = 1'b0;
   endtask

   function automatic logic [1:0] punch_fs(input int k);
      if (k <= 4) return 2'd1;
      if (k <= 8) return 2'd2;
      if (k <= 12) return 2'd3;
      return 2'd0;
   endfunction

   initial begin
      cyc(0, 500);
      do_reset();

      // Punch with a second edge during STRIKE; ticks counted from the entry tick
      frame(1, 1'b0, mk(2'd1, 100));
      for (int k = 2; k <= 14; k++) frame((k == 6) ? 1 : 0, 1'b0, mk(punch_fs(k), 100));

      // Punch with right held; edge on the RECOVER->IDLE tick is dropped
      move_right = 1'b1;
      frame(1, 1'b0, mk(2'd1, 100));
      for (int k = 2; k <= 12; k++) frame(0, 1'b0, mk(punch_fs(k), 100));
      frame(2, 1'b0, mk(2'd0, 100));
      frame(0, 1'b0, mk(2'd0, 102));
      move_right = 1'b0;

      // Left saturation at 0
      do_reset();
      move_left = 1'b1;
      for (int k = 1; k <= 60; k++) frame(0, 1'b0, mk(2'd0, (100 - 2 * k < 0) ? 0 : 100 - 2 * k));
      move_left = 1'b0;

      // Right saturation at X_MAX, then both / neither, then one step left
      do_reset();
      move_right = 1'b1;
      for (int k = 1; k <= 225; k++) frame(0, 1'b0, mk(2'd0, (100 + 2 * k > 548) ? 548 : 100 + 2 * k));
      move_left = 1'b1;
      for (int k = 0; k < 3; k++) frame(0, 1'b0, mk(2'd0, 548));
      move_left  = 1'b0;
      move_right = 1'b0;
      for (int k = 0; k < 2; k++) frame(0, 1'b0, mk(2'd0, 548));
      move_left = 1'b1;
      frame(0, 1'b0, mk(2'd0, 546));
      move_left = 1'b0;

      // Reset during WINDUP at x=200
      do_reset();
      move_right = 1'b1;
      for (int k = 1; k <= 50; k++) frame(0, 1'b0, mk(2'd0, 100 + 2 * k));
      move_right = 1'b0;
      frame(1, 1'b0, mk(2'd1, 200));
      frame(0, 1'b0, mk(2'd1, 200));
      do_reset();
      for (int k = 0; k < 3; k++) frame(0, 1'b0, mk(2'd0, 100));

      // Pending request dropped by reset
      punch_req = 1'b1;
      cyc(0, 500);
      cyc(0, 500);
      punch_req = 1'b0;
      cyc(0, 500);
      do_reset();
      for (int k = 0; k < 2; k++) frame(0, 1'b0, mk(2'd0, 100));

      // Reset wins over a coincident tick
      move_left = 1'b1;
      frame(0, 1'b0, mk(2'd0, 98));
      frame(0, 1'b1, mk(2'd0, 100));
      frame(0, 1'b0, mk(2'd0, 98));
      move_left = 1'b0;

      repeat (5) cyc(0, 500);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected snapshots never popped, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ryu_anim_seq.md
RYU_ANIM_SEQ -- requirements
Module: ryu_anim_seq

Interface
REQ-001 SHALL have parameter FRAME_HOLD, default 4: frame ticks each animation state is held (1..15).
REQ-002 SHALL have parameter X_INIT, default 100: sprite X position after reset.
REQ-003 SHALL have parameter X_MAX, default 548: rightmost legal sprite X (640 - 92).
REQ-004 SHALL have parameter STEP, default 2: pixels moved per frame tick.
REQ-005 SHALL have parameter Y_FIXED, default 300: constant sprite Y position.
REQ-006 SHALL have port vga_clk, input, 1: sole clock, rising-edge.
REQ-007 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have ports DrawX and DrawY, input, 10 each: current raster coordinates from the VGA controller.
REQ-009 SHALL have port punch_req, input, 1: punch key level, asynchronous to the frame.
REQ-010 SHALL have ports move_left and move_right, input, 1 each: movement key levels.
REQ-011 SHALL have ports sprite_x and sprite_y, output, 10 each: sprite top-left corner.
REQ-012 SHALL have port frame_sel, output, 2: animation frame index for the sprite drawer.
REQ-013 SHALL have port rom_base, output, 16: frame_sel * 8280 (92x90 words per frame).
REQ-014 SHALL have ports busy and hit_active, output, 1 each: busy = state not IDLE; hit_active = state is STRIKE.

Function
REQ-015 SHALL generate an internal one-cycle frame_tick when DrawX==0 and DrawY==480 (start of vertical blank).
REQ-016 SHALL change every output only on the cycle after frame_tick, so outputs are stable for all visible pixels of a frame.
REQ-017 SHALL detect punch_req rising edges with a registered previous value and set a pending flag on each edge.
REQ-018 SHALL have FSM states IDLE (frame 0), WINDUP (frame 1), STRIKE (frame 2) and RECOVER (frame 3).
REQ-019 SHALL, in IDLE at frame_tick with pending=1, go to WINDUP, clear pending and load hold_cnt=FRAME_HOLD-1.
REQ-020 SHALL, in a non-IDLE state at frame_tick, decrement hold_cnt if it is nonzero.
REQ-021 SHALL, in a non-IDLE state at frame_tick with hold_cnt==0, advance WINDUP->STRIKE->RECOVER->IDLE, reloading hold_cnt=FRAME_HOLD-1 on each non-IDLE entry.
REQ-022 SHALL clear (discard) pending on any punch_req edge arriving while the state is not IDLE; requests are not queued.
REQ-023 SHALL, when an edge coincides with the RECOVER->IDLE tick, discard that edge.
REQ-024 SHALL give each attack state exactly FRAME_HOLD ticks; a full punch lasts 3*FRAME_HOLD ticks.
REQ-025 SHALL apply movement only in IDLE, once per frame_tick.
REQ-026 SHALL, with left only, set sprite_x = max(sprite_x - STEP, 0), saturating with no wrap.
REQ-027 SHALL, with right only, set sprite_x = min(sprite_x + STEP, X_MAX), saturating.
REQ-028 SHALL leave sprite_x unchanged when both or neither movement input is asserted.
REQ-029 SHALL NOT move the sprite on the tick that leaves IDLE (the punch takes priority).
REQ-030 SHALL hold sprite_y at Y_FIXED at all times.
REQ-031 SHALL update rom_base in the same cycle as frame_sel and compute it with constant arithmetic; the largest value is 24840.

Reset
REQ-032 SHALL, on Reset high at a clock edge, set: state IDLE, frame_sel 0, rom_base 0, sprite_x X_INIT, sprite_y Y_FIXED, busy 0, hit_active 0, pending 0, hold_cnt 0, edge register 0.
REQ-033 SHALL, on Reset asserted mid-punch, abort the punch immediately and drop any pending request.
REQ-034 SHALL have Reset take priority over frame_tick in the same cycle.

Verification
REQ-035 SHALL cover: Reset, then 1 punch_req pulse mid-frame, FRAME_HOLD=4 -> next tick frame_sel=1, busy=1; after 4 ticks frame_sel=2, hit_active=1, rom_base=16560; after 12 ticks total frame_sel=0, busy=0.
REQ-036 SHALL cover: second punch_req edge during STRIKE -> ignored; the state is IDLE after tick 12 and stays IDLE at tick 13.
REQ-037 SHALL cover: move_left held 60 ticks from X_INIT=100 with STEP=2 -> sprite_x reaches 0 at tick 50 and stays 0.
REQ-038 SHALL cover: move_right held from sprite_x=546 -> 548 then stays 548; left+right together -> no change.
REQ-039 SHALL cover: Reset pulsed during WINDUP with sprite_x=200 -> next cycle IDLE, frame_sel=0, sprite_x=100, and no punch on following ticks.
REQ-040 SHALL cover: outputs sampled at every visible pixel (DrawY<480) across 3 frames -> no change between ticks.
